// File: rtl/muldiv_sequencer_if.sv
// Start/operand request and Hi/Lo result bundle between the control unit and the mul/div sequencer.
// Names take the sequencer's view: i_ is driven by the control unit and o_ by the sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             i_start_mult;
  logic             i_start_div;
  logic [WIDTH-1:0] i_op_a;
  logic [WIDTH-1:0] i_op_b;
  logic             o_busy;
  logic             o_done;
  logic             o_div_zero;
  logic [WIDTH-1:0] o_hi_result;
  logic [WIDTH-1:0] o_lo_result;
  logic             o_hi_sel;
  logic             o_lo_sel;
  logic             o_hi_write;
  logic             o_lo_write;

  modport master (
    output i_start_mult, i_start_div, i_op_a, i_op_b,
    input  o_busy, o_done, o_div_zero, o_hi_result, o_lo_result,
           o_hi_sel, o_lo_sel, o_hi_write, o_lo_write
  );

  modport slave (
    input  i_start_mult, i_start_div, i_op_a, i_op_b,
    output o_busy, o_done, o_div_zero, o_hi_result, o_lo_result,
           o_hi_sel, o_lo_sel, o_hi_write, o_lo_write
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed Booth multiply / restoring divide with Hi/Lo write sequencing; WIDTH+1 cycles (1 on divide-by-zero).
// No backpressure: starts are taken only in IDLE and anything arriving while busy is dropped.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_WRITE,
    S_DZERO
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH:0]   r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_bb, w_bb_nxt;
  logic [WIDTH-1:0] r_m, w_m_nxt;
  logic             r_qsign, w_qsign_nxt;
  logic             r_rsign, w_rsign_nxt;
  logic             r_sel, w_sel_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;

  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_booth_sum;
  logic [2*WIDTH+1:0] w_booth_shr;
  logic [WIDTH:0]     w_rem_shl;
  logic               w_rem_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [WIDTH-1:0]   w_rem_new;
  logic [WIDTH-1:0]   w_q_div;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_last;

  // Accumulator carries one extra sign bit so that negating INT_MIN cannot overflow.
  assign w_m_ext = {r_m[WIDTH-1], r_m};

  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_bb})
      2'b01:   w_booth_sum = r_acc + w_m_ext;
      2'b10:   w_booth_sum = r_acc - w_m_ext;
      default: w_booth_sum = r_acc;
    endcase
  end

  assign w_booth_shr = $signed({w_booth_sum, r_q, r_bb}) >>> 1;

  // Restoring step: r_acc low half is the partial remainder, r_q shifts dividend out and quotient in.
  assign w_rem_shl = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_rem_ge  = (w_rem_shl >= {1'b0, r_m});
  assign w_rem_sub = w_rem_shl[WIDTH-1:0] - r_m;
  assign w_rem_new = w_rem_ge ? w_rem_sub : w_rem_shl[WIDTH-1:0];
  assign w_q_div   = {r_q[WIDTH-2:0], w_rem_ge};

  assign w_abs_a = bus.i_op_a[WIDTH-1] ? -bus.i_op_a : bus.i_op_a;
  assign w_abs_b = bus.i_op_b[WIDTH-1] ? -bus.i_op_b : bus.i_op_b;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_q_nxt     = r_q;
    w_bb_nxt    = r_bb;
    w_m_nxt     = r_m;
    w_qsign_nxt = r_qsign;
    w_rsign_nxt = r_rsign;
    w_sel_nxt   = r_sel;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start_mult) begin
          w_m_nxt     = bus.i_op_a;
          w_q_nxt     = bus.i_op_b;
          w_acc_nxt   = '0;
          w_bb_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 1'b1;
          w_state_nxt = S_MULT;
        end else if (bus.i_start_div) begin
          w_m_nxt     = w_abs_b;
          w_q_nxt     = w_abs_a;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_qsign_nxt = bus.i_op_a[WIDTH-1] ^ bus.i_op_b[WIDTH-1];
          w_rsign_nxt = bus.i_op_a[WIDTH-1];
          w_sel_nxt   = 1'b0;
          w_state_nxt = (bus.i_op_b == '0) ? S_DZERO : S_DIV;
        end
      end
      S_MULT: begin
        w_acc_nxt = w_booth_shr[2*WIDTH+1:WIDTH+1];
        w_q_nxt   = w_booth_shr[WIDTH:1];
        w_bb_nxt  = w_booth_shr[0];
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_hi_nxt    = w_booth_shr[2*WIDTH:WIDTH+1];
          w_lo_nxt    = w_booth_shr[WIDTH:1];
          w_state_nxt = S_WRITE;
        end
      end
      S_DIV: begin
        w_acc_nxt = {1'b0, w_rem_new};
        w_q_nxt   = w_q_div;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_hi_nxt    = r_rsign ? -w_rem_new : w_rem_new;
          w_lo_nxt    = r_qsign ? -w_q_div : w_q_div;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      S_DZERO: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_bb    <= 1'b0;
      r_m     <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_sel   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_q     <= w_q_nxt;
      r_bb    <= w_bb_nxt;
      r_m     <= w_m_nxt;
      r_qsign <= w_qsign_nxt;
      r_rsign <= w_rsign_nxt;
      r_sel   <= w_sel_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_done      = (r_state == S_WRITE) || (r_state == S_DZERO);
  assign bus.o_div_zero  = (r_state == S_DZERO);
  assign bus.o_hi_write  = (r_state == S_WRITE);
  assign bus.o_lo_write  = (r_state == S_WRITE);
  assign bus.o_hi_sel    = r_sel;
  assign bus.o_lo_sel    = r_sel;
  assign bus.o_hi_result = r_hi;
  assign bus.o_lo_result = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus random checks of muldiv_sequencer against 64-bit signed arithmetic.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
    check({tag, "_done"}, 64'(bus.o_done), 64'd0);
    check({tag, "_dz"}, 64'(bus.o_div_zero), 64'd0);
    check({tag, "_wr"}, 64'({bus.o_hi_write, bus.o_lo_write}), 64'd0);
    check({tag, "_sel"}, 64'({bus.o_hi_sel, bus.o_lo_sel}), 64'd0);
    check({tag, "_hi"}, 64'(bus.o_hi_result), 64'd0);
    check({tag, "_lo"}, 64'(bus.o_lo_result), 64'd0);
  endtask

  // kind: 0 multiply, 1 divide, 2 both starts together. inj: cycle in which a stray start_div is pulsed.
  task automatic run_op(input string tag, input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj);
    logic signed [63:0] sa, sb, p, q, r;
    logic [W-1:0] e_hi, e_lo;
    logic e_dz, e_sel, seen, busy_ok, strobe_ok, sel_ok;
    int e_lat, lat;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    e_dz = 1'b0;
    if (kind != 1) begin
      p = sa * sb;
      e_hi = p[63:32];
      e_lo = p[31:0];
      e_sel = 1'b1;
      e_lat = W + 1;
    end else if (b == '0) begin
      e_hi = exp_hi;
      e_lo = exp_lo;
      e_dz = 1'b1;
      e_sel = 1'b0;
      e_lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e_hi = r[31:0];
      e_lo = q[31:0];
      e_sel = 1'b0;
      e_lat = W + 1;
    end

    @(negedge clk);
    bus.i_start_mult = (kind != 1);
    bus.i_start_div  = (kind != 0);
    bus.i_op_a = a;
    bus.i_op_b = b;
    @(negedge clk);
    bus.i_start_mult = 1'b0;
    bus.i_start_div  = 1'b0;
    bus.i_op_a = $urandom;
    bus.i_op_b = $urandom;

    seen = 1'b0; busy_ok = 1'b1; strobe_ok = 1'b1; sel_ok = 1'b1; lat = 0;
    for (int c = 1; c <= 40; c++) begin
      lat = c;
      if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
      if ({bus.o_hi_sel, bus.o_lo_sel} !== {e_sel, e_sel}) sel_ok = 1'b0;
      if (bus.o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if ({bus.o_hi_write, bus.o_lo_write, bus.o_div_zero} !== 3'b000) strobe_ok = 1'b0;
      bus.i_start_div = (c == inj);
      @(negedge clk);
      bus.i_start_div = 1'b0;
    end

    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(e_lat));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_strobe"}, 64'(strobe_ok), 64'd1);
    check({tag, "_sel"}, 64'(sel_ok), 64'd1);
    check({tag, "_dz"}, 64'(bus.o_div_zero), 64'(e_dz));
    check({tag, "_wr"}, 64'({bus.o_hi_write, bus.o_lo_write}), e_dz ? 64'd0 : 64'd3);
    check({tag, "_hi"}, 64'(bus.o_hi_result), 64'(e_hi));
    check({tag, "_lo"}, 64'(bus.o_lo_result), 64'(e_lo));
    exp_hi = e_hi;
    exp_lo = e_lo;

    @(negedge clk);
    check({tag, "_after"}, 64'({bus.o_busy, bus.o_done, bus.o_hi_write, bus.o_lo_write}), 64'd0);
    check({tag, "_hold"}, {32'(bus.o_hi_result), 32'(bus.o_lo_result)}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic no_done;
    int kind;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    bus.i_start_mult = 1'b0;
    bus.i_start_div  = 1'b0;
    bus.i_op_a = '0;
    bus.i_op_b = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run_op("mul_7_m3", 0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_100_7", 1, 32'd100, 32'd7, 0);
    run_op("div_5_0", 1, 32'd5, 32'd0, 0);
    run_op("div_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mul_min_min", 0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mul_m1_m1", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_m9_m4", 1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 0);
    run_op("mul_coll", 0, 32'h1234_5678, 32'hFEDC_BA98, 10);
    run_op("both", 2, 32'd123, 32'hFFFF_FF00, 0);

    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 1);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
      run_op($sformatf("rnd%0d", i), kind, ra, rb, 0);
    end

    run_op("pre_rst", 0, 32'd7, 32'hFFFF_FFFD, 0);
    @(negedge clk);
    bus.i_start_div = 1'b1;
    bus.i_op_a = 32'hFFFF_FF9C;
    bus.i_op_b = 32'd3;
    @(negedge clk);
    bus.i_start_div = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_busy", 64'(bus.o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    no_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if ((bus.o_done | bus.o_hi_write | bus.o_lo_write) !== 1'b0) no_done = 1'b0;
    end
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    repeat (40) begin
      @(negedge clk);
      if ((bus.o_done | bus.o_hi_write | bus.o_lo_write) !== 1'b0) no_done = 1'b0;
    end
    check("rst_abort", 64'(no_done), 64'd1);
    run_op("mul_3_4", 0, 32'd3, 32'd4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
